// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves execute-stage branches/jumps, redirects fetch on mispredict, trains a 2-bit BHT.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            BrUn,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);
  typedef enum logic {IDLE, FLUSH} state_e;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int NE = 1 << BHT_IDX;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]       branch_count_q, branch_count_d;
  logic [31:0]       mispredict_count_q, mispredict_count_d;
  logic [1:0]        bht_q [NE];
  logic [1:0]        bht_d;
  logic [BHT_IDX-1:0] ex_idx, if_idx;
  logic              accept, is_jump, is_br, f3_ok, br_taken, taken, mispredict, bht_we;
  logic              unused_pc_bits;

  assign ex_idx         = ex_pc[BHT_IDX+1:2];
  assign if_idx         = if_pc[BHT_IDX+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0]};

  assign BrUn          = ex_funct3[2:1] == 2'b11;
  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    accept     = ex_valid && state_q == IDLE;
    is_jump    = ex_is_jump;
    is_br      = ex_is_branch && !ex_is_jump;
    f3_ok      = ex_funct3[2:1] != 2'b01;
    // funct3[0] inverts the sense; funct3[2] picks less-than over equal
    br_taken   = ex_funct3[0] ^ (ex_funct3[2] ? BrLT : BrEq);
    taken      = is_jump || (is_br && f3_ok && br_taken);
    mispredict = accept && (is_jump || (is_br && taken != ex_pred_taken));
    bht_we     = accept && is_br && f3_ok;
    bht_d      = taken ? (bht_q[ex_idx] == 2'b11 ? 2'b11 : bht_q[ex_idx] + 2'b01)
                       : (bht_q[ex_idx] == 2'b00 ? 2'b00 : bht_q[ex_idx] - 2'b01);
    redirect_valid_d   = mispredict;
    redirect_pc_d      = !mispredict ? redirect_pc_q : taken ? ex_target : ex_pc + XLEN'(4);
    branch_count_d     = branch_count_q + 32'((accept && is_br) && branch_count_q != '1);
    mispredict_count_d = mispredict_count_q + 32'(mispredict && mispredict_count_q != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = mispredict ? FLUSH : IDLE;
      cnt_d   = mispredict ? CW'(FLUSH_CYCLES) : '0;
    end else begin
      state_d = cnt_q == CW'(1) ? IDLE : FLUSH;
      cnt_d   = cnt_q - CW'(1);
    end
  end

  always_comb begin
    flush = state_q == FLUSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int k = 0; k < NE; k++) bht_q[k] <= 2'b01;
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      if (bht_we) bht_q[ex_idx] <= bht_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of redirect, flush, BHT training and counters.
module tb_branch_resolve_unit;
  logic        clk = 0, rst = 1;
  logic        ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, if_pc = 32'h100;
  logic [2:0]  ex_funct3 = 0;
  logic        BrEq = 0, BrLT = 0;
  logic        BrUn, if_pred_taken, redirect_valid, flush;
  logic [31:0] redirect_pc, branch_count, mispredict_count;
  int          passed = 0, total = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic eq, input logic lt,
                    input logic pred, input logic [31:0] tgt, input logic b, input logic j);
    ex_valid = 1; ex_pc = pc; ex_funct3 = f3; BrEq = eq; BrLT = lt;
    ex_pred_taken = pred; ex_target = tgt; ex_is_branch = b; ex_is_jump = j;
  endtask

  initial begin
    #1;
    chk("rst_pred", 32'(if_pred_taken), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_bc", branch_count, 0);
    chk("rst_mc", mispredict_count, 0);
    chk("rst_brun", 32'(BrUn), 0);
    @(negedge clk); rst = 0;
    tick();
    // BEQ taken, predicted not-taken
    br(32'h40, 3'b000, 1, 0, 0, 32'h80, 1, 0);
    if_pc = 32'h40;
    #1 chk("beq_pred_pre", 32'(if_pred_taken), 0);
    tick(); ex_valid = 0;
    chk("beq_rv", 32'(redirect_valid), 1);
    chk("beq_rpc", redirect_pc, 32'h80);
    chk("beq_flush1", 32'(flush), 1);
    chk("beq_mc", mispredict_count, 1);
    chk("beq_bc", branch_count, 1);
    chk("beq_bht", 32'(if_pred_taken), 1);
    tick();
    chk("beq_rv_off", 32'(redirect_valid), 0);
    chk("beq_flush2", 32'(flush), 1);
    chk("beq_rpc_hold", redirect_pc, 32'h80);
    tick();
    chk("beq_flush_end", 32'(flush), 0);
    // BLTU not taken twice, then taken: bht[1] 01->00->00->01
    br(32'h44, 3'b110, 0, 0, 0, 32'h90, 1, 0);
    if_pc = 32'h44;
    #1 chk("bltu_brun", 32'(BrUn), 1);
    tick();
    chk("bltu_rv", 32'(redirect_valid), 0);
    chk("bltu_flush", 32'(flush), 0);
    chk("bltu_bc", branch_count, 2);
    tick();
    chk("bltu_bc2", branch_count, 3);
    br(32'h44, 3'b110, 0, 1, 1, 32'h90, 1, 0);
    tick();
    chk("bltu_sat0", 32'(if_pred_taken), 0);
    chk("bltu_rv3", 32'(redirect_valid), 0);
    chk("bltu_bc3", branch_count, 4);
    // JALR with two follow-on mispredicting branches during flush
    br(32'h10, 3'b000, 0, 0, 0, 32'h200, 0, 1);
    tick();
    chk("jalr_rv", 32'(redirect_valid), 1);
    chk("jalr_rpc", redirect_pc, 32'h200);
    chk("jalr_mc", mispredict_count, 2);
    chk("jalr_bc", branch_count, 4);
    br(32'h48, 3'b000, 1, 0, 0, 32'h400, 1, 0);
    tick();
    chk("jalr_ign_rv", 32'(redirect_valid), 0);
    chk("jalr_ign_mc", mispredict_count, 2);
    chk("jalr_ign_bc", branch_count, 4);
    tick(); ex_valid = 0;
    chk("jalr_ign2_flush", 32'(flush), 0);
    chk("jalr_ign2_mc", mispredict_count, 2);
    chk("jalr_ign2_bc", branch_count, 4);
    chk("jalr_ign2_rpc", redirect_pc, 32'h200);
    // BNE predicted taken but falls through; reset mid-flush
    br(32'h20, 3'b001, 1, 0, 1, 32'h500, 1, 0);
    tick(); ex_valid = 0;
    chk("bne_rpc", redirect_pc, 32'h24);
    chk("bne_mc", mispredict_count, 3);
    tick();
    chk("bne_flush2", 32'(flush), 1);
    rst = 1; if_pc = 32'h40;
    #1;
    chk("arst_flush", 32'(flush), 0);
    chk("arst_bht", 32'(if_pred_taken), 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_mc", mispredict_count, 0);
    chk("arst_bc", branch_count, 0);
    @(negedge clk); rst = 0;
    // Four taken BGE at idx 8: 01->10->11->11->11
    br(32'h60, 3'b101, 0, 0, 1, 32'h600, 1, 0);
    if_pc = 32'h60;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bge_rv", 32'(redirect_valid), 0);
    end
    chk("bge_bc", branch_count, 4);
    chk("bge_mc", mispredict_count, 0);
    chk("bge_pred", 32'(if_pred_taken), 1);
    br(32'h60, 3'b101, 0, 1, 0, 32'h600, 1, 0);
    tick();
    chk("bge_sat11", 32'(if_pred_taken), 1);
    br(32'h60, 3'b010, 0, 0, 0, 32'h600, 1, 0);
    tick();
    chk("f3_010_bc", branch_count, 6);
    chk("f3_010_rv", 32'(redirect_valid), 0);
    chk("f3_010_bht", 32'(if_pred_taken), 1);
    br(32'h60, 3'b000, 0, 0, 0, 32'h300, 1, 1);
    tick(); ex_valid = 0;
    chk("both_rv", 32'(redirect_valid), 1);
    chk("both_rpc", redirect_pc, 32'h300);
    chk("both_bc", branch_count, 6);
    chk("both_bht", 32'(if_pred_taken), 1);
    tick(); tick();
    chk("both_flush_end", 32'(flush), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch comparator's BrEq/BrLT outputs; also drives the comparator's BrUn select from funct3.
- Decides branch/jump direction and checks it against the fetch-time prediction.
- Issues a registered PC redirect plus a fixed-length pipeline flush on mispredict.
- Maintains a 2-bit saturating branch history table (BHT) read by fetch, and 32-bit performance counters.

Parameters:
- XLEN, 32, datapath/PC width
- BHT_IDX, 4, log2 of BHT entries (16 entries, indexed by pc[BHT_IDX+1:2])
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  XLEN  PC of execute-stage instruction
- ex_funct3  in  3  funct3 of execute-stage instruction
- ex_is_branch  in  1  conditional branch (B-type)
- ex_is_jump  in  1  JAL or JALR
- ex_target  in  XLEN  ALU-computed taken target
- ex_pred_taken  in  1  prediction carried from fetch for this instruction
- BrEq  in  1  comparator equal
- BrLT  in  1  comparator less-than
- BrUn  out  1  unsigned-compare select to comparator
- if_pc  in  XLEN  fetch PC for BHT lookup
- if_pred_taken  out  1  BHT prediction for if_pc
- redirect_valid  out  1  one-cycle redirect strobe to fetch
- redirect_pc  out  XLEN  corrected next PC
- flush  out  1  kill wrong-path instructions in IF/ID
- branch_count  out  32  resolved conditional branches
- mispredict_count  out  32  redirects issued

Behaviour:
- BrUn: combinational; 1 iff ex_funct3 is 3'b110 or 3'b111; otherwise 0.
- if_pred_taken: combinational; bht[if_pc[BHT_IDX+1:2]][1].
- Taken decode by funct3:
  - 000 BEQ: BrEq
  - 001 BNE: !BrEq
  - 100 BLT: BrLT
  - 101 BGE: !BrLT
  - 110 BLTU: BrLT
  - 111 BGEU: !BrLT
  - 010/011: not taken, no BHT update, still counted
- Jumps: always taken; always redirect; no BHT update; not counted in branch_count.
- Accepted instruction: ex_valid=1 AND state==IDLE.
  - In FLUSH state, ex_valid is ignored entirely: no update, no count, no redirect.
  - ex_is_branch and ex_is_jump both set: treated as a jump.
- Mispredict: accepted branch with taken != ex_pred_taken, or any accepted jump.
- Redirect timing: mispredict at edge N gives redirect_valid=1 for exactly cycle N+1.
  - redirect_pc = taken ? ex_target : ex_pc+4 (modulo 2^XLEN).
  - redirect_pc holds its last value otherwise.
- FSM states: IDLE and FLUSH.
  - IDLE -> FLUSH on mispredict; flush counter loads FLUSH_CYCLES.
  - flush=1 while in FLUSH; counter decrements each cycle.
  - FLUSH -> IDLE when counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES).
- BHT update (accepted branch, funct3 valid):
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
  - Written at clock edge; same-cycle if_pc read of the same index returns the pre-update value.
- Counters:
  - branch_count +1 per accepted branch.
  - mispredict_count +1 per redirect.
  - Both saturate at 32'hFFFFFFFF (no wrap).
- Reset (asynchronous, any cycle including mid-flush):
  - state=IDLE, counter=0.
  - redirect_valid=0, redirect_pc=0, flush=0.
  - All BHT entries=2'b01 (weakly not-taken); both perf counters=0.
  - First edge after rst deasserts behaves as IDLE.

Test Plan:
- Reset, if_pc=0x100 -> if_pred_taken=0; all outputs 0; BrUn=0 for funct3=000.
- BEQ at pc=0x40, BrEq=1, pred=0, target=0x80 -> next cycle redirect_valid=1, redirect_pc=0x80; flush=1 for 2 cycles; mispredict_count=1; bht[0] becomes 2'b10, so if_pc=0x40 gives pred=1.
- BLTU funct3=110 at pc=0x44, BrLT=0, pred=0 -> BrUn=1; no redirect; flush stays 0; branch_count +1; bht[1]=2'b00. Repeat with pred=0 -> bht[1] stays 2'b00.
- JALR at pc=0x10, target=0x200, with ex_valid=1 on both following cycles -> single redirect to 0x200; the two follow-on instructions are ignored (counts unchanged).
- BNE mispredict (pred=1, BrEq=1) at pc=0x20 -> redirect_pc=0x24; assert rst during second flush cycle -> flush=0 and bht[8]=2'b01 immediately, before the next edge.
- Four consecutive taken BGE at the same pc (BrLT=0, pred=1) -> counter saturates at 2'b11; no redirects; branch_count=4.
